uart_tx_fifo: RTL and testbench

Parametrised successor to the team's single-byte UART transmitter. Adds:
- configurable data width, parity mode and stop-bit count
- an internal transmit FIFO, so the host can queue several characters
- back-to-back frames with no idle gap between them

It sits between the accelerator result/debug logic and the board TX pin, and reuses the existing baud-divisor convention: CLKS_PER_BIT = clock frequency / baud rate.

---
 rtl/uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small character FIFO; configurable data width, parity and stop bits.
// Latency: write into an empty idle FIFO -> line falls 2 cycles later; frames go out back to back.
// Backpressure: o_Tx_Ready low while FIFO full; writes then are dropped and flagged on o_Tx_Overflow.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Overflow,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Terminal counts; the clock counter is sized for the longest (stop) period.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW:0]          count_nxt;
    logic                 ready_q;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Serialiser datapath
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 head_par;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 bit_end;
    logic                 stop_end;

    // FSM combinational outputs, registered before reaching the pins
    logic serial_c;
    logic active_c;
    logic done_c;
    logic serial_q;
    logic active_q;
    logic done_q;

    // A write is taken only when the registered count says there is room,
    // so a pop in the same cycle never rescues a write into a full FIFO.
    assign push     = i_Tx_DV && ready_q;
    assign head     = mem[rd_ptr];
    assign head_par = ^head;
    assign bit_end  = (clk_cnt == BIT_LAST);
    assign stop_end = (clk_cnt == STOP_LAST);

    // FIFO storage write; contents need no reset since count gates all reads
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers, count, ready flag and overflow pulse
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_nxt;
            ready_q    <= (count_nxt != FULL_CNT);
            overflow_q <= i_Tx_DV && !ready_q;
        end
    end

    // FSM state register
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; the pop happens on the edge that starts a new frame
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == IDX_LAST)) begin
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    // Chain straight into the next frame when one is waiting
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs as seen on the line one cycle later
    always_comb begin
        serial_c = 1'b1;
        active_c = 1'b0;
        done_c   = 1'b0;
        case (state)
            S_START: begin
                serial_c = 1'b0;
                active_c = 1'b1;
            end
            S_DATA: begin
                serial_c = shreg[0];
                active_c = 1'b1;
            end
            S_PARITY: begin
                serial_c = par_bit;
                active_c = 1'b1;
            end
            S_STOP: begin
                serial_c = 1'b1;
                active_c = 1'b1;
                done_c   = stop_end;
            end
            default: begin
                serial_c = 1'b1;
                active_c = 1'b0;
            end
        endcase
    end

    // Shift register, parity and bit/clock counters
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            shreg   <= '0;
            par_bit <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else if (pop) begin
            shreg   <= head;
            par_bit <= (PARITY == 1) ? ~head_par : head_par;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_START, S_PARITY: begin
                    clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shreg   <= shreg >> 1;
                        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + BW'(1);
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    clk_cnt <= stop_end ? '0 : clk_cnt + CW'(1);
                end
                default: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Output registers; the line goes high on the edge reset is seen
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            serial_q <= serial_c;
            active_q <= active_c;
            done_q   <= done_c;
        end
    end

    assign o_Tx_Serial   = serial_q;
    assign o_Tx_Active   = active_q;
    assign o_Tx_Done     = done_q;
    assign o_Tx_Ready    = ready_q;
    assign o_Tx_Overflow = overflow_q;
    assign o_Fifo_Count  = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O2, 7N1) at 4 clocks per bit.
// A transaction-level model predicts line, Done, Active, count, Ready and Overflow per cycle.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dv   [4];
    logic [7:0] din  [4];
    logic       rdy  [4];
    logic       ovf  [4];
    logic       act  [4];
    logic       ser  [4];
    logic       done [4];
    logic [2:0] cnt  [4];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .i_Clock(clk), .reset(reset), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0]),
        .o_Tx_Ready(rdy[0]), .o_Fifo_Count(cnt[0]), .o_Tx_Overflow(ovf[0]),
        .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
        .i_Clock(clk), .reset(reset), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1]),
        .o_Tx_Ready(rdy[1]), .o_Fifo_Count(cnt[1]), .o_Tx_Overflow(ovf[1]),
        .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u2 (
        .i_Clock(clk), .reset(reset), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2]),
        .o_Tx_Ready(rdy[2]), .o_Fifo_Count(cnt[2]), .o_Tx_Overflow(ovf[2]),
        .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u3 (
        .i_Clock(clk), .reset(reset), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[3][6:0]),
        .o_Tx_Ready(rdy[3]), .o_Fifo_Count(cnt[3]), .o_Tx_Overflow(ovf[3]),
        .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));

    int checks   = 0;
    int failures = 0;
    int cur      = 0;
    int NB [4];
    int PM [4];
    int SB [4];

    // Model state: edge number, earliest edge a new frame may start, queued bytes, started frames
    typedef struct {
        int         p;
        logic [7:0] d;
    } frame_t;

    int         edge_n;
    int         t_free;
    logic [7:0] mq[$];
    frame_t     frames[$];
    logic       exp_line, exp_act, exp_done, exp_ovf, exp_rdy;
    int         exp_cnt;

    function automatic int flen(input int k);
        return (1 + NB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]) * CPB;
    endfunction

    // Line level at cycle offset o within the frame carrying d
    function automatic logic fbit(input int k, input logic [7:0] d, input int o);
        int   slot;
        logic p;
        slot = o / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= NB[k]) return d[slot-1];
        if ((PM[k] != 0) && (slot == NB[k] + 1)) begin
            p = 1'b0;
            for (int i = 0; i < NB[k]; i++) p ^= d[i];
            return (PM[k] == 1) ? ~p : p;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        t_free = 0;
        mq.delete();
        frames.delete();
        exp_line = 1'b1; exp_act = 1'b0; exp_done = 1'b0;
        exp_ovf  = 1'b0; exp_rdy = 1'b1; exp_cnt  = 0;
    endtask

    // One rising edge: a frame starts (pop) whenever something is queued and the
    // previous frame has reached its final cycle; it appears on the line one edge later.
    task automatic model_edge(input logic v, input logic [7:0] d);
        int     cb;
        int     o;
        int     len;
        frame_t f;
        len = flen(cur);
        edge_n++;
        cb = mq.size();
        exp_ovf = v && (cb >= DEPTH);
        if (cb > 0 && edge_n >= t_free) begin
            f.p = edge_n;
            f.d = mq.pop_front();
            frames.push_back(f);
            t_free = edge_n + len;
        end
        if (v && cb < DEPTH) mq.push_back(d);
        while (frames.size() > 0 && frames[0].p + len < edge_n) void'(frames.pop_front());
        exp_line = 1'b1; exp_act = 1'b0; exp_done = 1'b0;
        foreach (frames[i]) begin
            o = edge_n - (frames[i].p + 1);
            if (o >= 0 && o < len) begin
                exp_line = fbit(cur, frames[i].d, o);
                exp_act  = 1'b1;
            end
            if (edge_n == frames[i].p + len) exp_done = 1'b1;
        end
        exp_cnt = mq.size();
        exp_rdy = (exp_cnt < DEPTH);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        dv[cur]  = v;
        din[cur] = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        dv[cur] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) dv[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser[k] !== 1'b1 || rdy[k] !== 1'b1 || cnt[k] !== 3'd0 ||
                act[k] !== 1'b0 || done[k] !== 1'b0 || ovf[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state k=%0d got ser=%b rdy=%b cnt=%0d act=%b done=%b ovf=%b exp 1 1 0 0 0 0",
                         k, ser[k], rdy[k], cnt[k], act[k], done[k], ovf[k]);
            end
        end
    endtask

    // Single 0xA5 frame on 8N1: latency, bit sequence, Done position
    task automatic test_single_frame();
        logic       hist [80];
        logic [9:0] seq;
        int         fall, dpos, nd, idx;
        cur = 0;
        do_reset();
        cyc(1'b1, 8'hA5);
        fall = -1; dpos = -1; nd = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b0, 8'h00);
            hist[i] = ser[0];
            if (ser[0] == 1'b0 && fall < 0) fall = i;
            if (done[0]) begin nd++; dpos = i; end
            checks++;
            if (ser[0] !== exp_line || done[0] !== exp_done || act[0] !== exp_act) begin
                failures++;
                $display("FAIL single_cycle i=%0d got ser/done/act=%b%b%b exp=%b%b%b",
                         i, ser[0], done[0], act[0], exp_line, exp_done, exp_act);
            end
        end
        // Cycle 0 is the pop edge; the start bit must appear on the next one
        checks++;
        if (fall !== 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=1", fall);
        end
        seq = {1'b1, 8'hA5, 1'b0};
        for (int s = 0; s < 10; s++) begin
            idx = ((fall < 0) ? 0 : fall) + 4 * s + 2;
            if (idx > 79) idx = 79;
            checks++;
            if (hist[idx] !== seq[s]) begin
                failures++;
                $display("FAIL single_bit slot=%0d got=%b exp=%b", s, hist[idx], seq[s]);
            end
        end
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("FAIL single_done_count got=%0d exp=1", nd);
        end
        // Done marks the final stop-bit cycle of the 40-cycle frame
        checks++;
        if (dpos - fall !== 39) begin
            failures++;
            $display("FAIL single_done_pos got=%0d exp=39", dpos - fall);
        end
    endtask

    // 0xA5 with even parity (1 stop) and odd parity (2 stops)
    task automatic test_parity();
        logic hist [80];
        int   fall, dpos, idx, dist_exp;
        logic pb_exp;
        for (int k = 1; k <= 2; k++) begin
            cur = k;
            do_reset();
            cyc(1'b1, 8'hA5);
            fall = -1; dpos = -1;
            for (int i = 0; i < 80; i++) begin
                cyc(1'b0, 8'h00);
                hist[i] = ser[k];
                if (ser[k] == 1'b0 && fall < 0) fall = i;
                if (done[k]) dpos = i;
                checks++;
                if (ser[k] !== exp_line || done[k] !== exp_done || act[k] !== exp_act) begin
                    failures++;
                    $display("FAIL parity_cycle k=%0d i=%0d got=%b%b%b exp=%b%b%b",
                             k, i, ser[k], done[k], act[k], exp_line, exp_done, exp_act);
                end
            end
            pb_exp   = (k == 1) ? 1'b0 : 1'b1;
            dist_exp = (k == 1) ? 43 : 47;
            idx = ((fall < 0) ? 0 : fall) + 4 * 9 + 2;
            checks++;
            if (hist[idx] !== pb_exp) begin
                failures++;
                $display("FAIL parity_bit k=%0d got=%b exp=%b", k, hist[idx], pb_exp);
            end
            checks++;
            if (hist[idx + 4] !== 1'b1 || hist[idx + 4 * (k - 1) + 4] !== 1'b1) begin
                failures++;
                $display("FAIL parity_stop k=%0d got=%b%b exp=11", k, hist[idx + 4], hist[idx + 4 * (k - 1) + 4]);
            end
            checks++;
            if (dpos - fall !== dist_exp) begin
                failures++;
                $display("FAIL parity_len k=%0d got=%0d exp=%0d", k, dpos - fall, dist_exp);
            end
        end
    endtask

    // 7N1 frame of 0x7F: start, seven ones, stop; 36 cycles
    task automatic test_data7();
        logic hist [60];
        int   fall, dpos, idx;
        cur = 3;
        do_reset();
        cyc(1'b1, 8'h7F);
        fall = -1; dpos = -1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 8'h00);
            hist[i] = ser[3];
            if (ser[3] == 1'b0 && fall < 0) fall = i;
            if (done[3]) dpos = i;
        end
        for (int s = 0; s < 9; s++) begin
            idx = ((fall < 0) ? 0 : fall) + 4 * s + 2;
            checks++;
            if (hist[idx] !== ((s == 0) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL data7_bit slot=%0d got=%b exp=%b", s, hist[idx], (s == 0) ? 1'b0 : 1'b1);
            end
        end
        checks++;
        if (dpos - fall !== 35) begin
            failures++;
            $display("FAIL data7_len got=%0d exp=35", dpos - fall);
        end
    endtask

    // Six writes on consecutive cycles into a depth-4 FIFO, then drain
    task automatic test_back_to_back();
        int   novf, nd, gaps;
        logic started;
        cur = 0;
        do_reset();
        novf = 0;
        for (int b = 1; b <= 6; b++) begin
            cyc(1'b1, 8'(b));
            if (ovf[0]) novf++;
            checks++;
            if (ovf[0] !== exp_ovf || rdy[0] !== exp_rdy || cnt[0] !== 3'(exp_cnt)) begin
                failures++;
                $display("FAIL b2b_write b=%0d got ovf=%b rdy=%b cnt=%0d exp %b %b %0d",
                         b, ovf[0], rdy[0], cnt[0], exp_ovf, exp_rdy, exp_cnt);
            end
            if (b == 5) begin
                // First byte was popped on the second write's edge, so the fifth still fits
                checks++;
                if (cnt[0] !== 3'd4 || rdy[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full got cnt=%0d rdy=%b exp 4 0", cnt[0], rdy[0]);
                end
            end
        end
        checks++;
        if (novf !== 1) begin
            failures++;
            $display("FAIL b2b_overflow_count got=%0d exp=1", novf);
        end
        nd = 0; gaps = 0; started = 1'b0;
        for (int i = 0; i < 230; i++) begin
            cyc(1'b0, 8'h00);
            if (act[0]) started = 1'b1;
            if (started && nd < 5 && !act[0]) gaps++;
            if (done[0]) nd++;
            checks++;
            if (ser[0] !== exp_line || done[0] !== exp_done || act[0] !== exp_act ||
                cnt[0] !== 3'(exp_cnt) || rdy[0] !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_cycle i=%0d got ser=%b done=%b act=%b cnt=%0d rdy=%b exp %b %b %b %0d %b",
                         i, ser[0], done[0], act[0], cnt[0], rdy[0], exp_line, exp_done, exp_act, exp_cnt, exp_rdy);
            end
        end
        checks++;
        if (nd !== 5 || gaps !== 0) begin
            failures++;
            $display("FAIL b2b_frames got done=%0d gaps=%0d exp 5 0", nd, gaps);
        end
    endtask

    // Reset in the middle of the data bits with two bytes still queued
    task automatic test_reset_mid();
        cur = 0;
        do_reset();
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'h5A);
        cyc(1'b1, 8'h66);
        repeat (14) cyc(1'b0, 8'h00);
        checks++;
        if (cnt[0] !== 3'd2 || act[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got cnt=%0d act=%b exp 2 1", cnt[0], act[0]);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ser[0] !== 1'b1 || act[0] !== 1'b0 || cnt[0] !== 3'd0 || done[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got ser=%b act=%b cnt=%0d done=%b rdy=%b exp 1 0 0 0 1",
                     ser[0], act[0], cnt[0], done[0], rdy[0]);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 8'h00);
            checks++;
            if (ser[0] !== 1'b1 || done[0] !== 1'b0 || act[0] !== 1'b0) begin
                failures++;
                $display("FAIL mid_after i=%0d got ser=%b done=%b act=%b exp 1 0 0", i, ser[0], done[0], act[0]);
            end
        end
    endtask

    // Random write traffic on every configuration, then drain
    task automatic test_random();
        logic       v;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            cur = k;
            do_reset();
            for (int i = 0; i < 800; i++) begin
                v = (i < 500) && ($urandom_range(0, 99) < 35);
                d = 8'($urandom);
                cyc(v, d);
                checks++;
                if (ser[k] !== exp_line || done[k] !== exp_done || act[k] !== exp_act ||
                    cnt[k] !== 3'(exp_cnt) || rdy[k] !== exp_rdy || ovf[k] !== exp_ovf) begin
                    failures++;
                    $display("FAIL rand k=%0d i=%0d got ser=%b done=%b act=%b cnt=%0d rdy=%b ovf=%b exp %b %b %b %0d %b %b",
                             k, i, ser[k], done[k], act[k], cnt[k], rdy[k], ovf[k],
                             exp_line, exp_done, exp_act, exp_cnt, exp_rdy, exp_ovf);
                end
            end
        end
    endtask

    initial begin
        NB = '{8, 8, 8, 7};
        PM = '{0, 2, 1, 0};
        SB = '{1, 1, 2, 1};
        for (int k = 0; k < 4; k++) begin
            dv[k]  = 1'b0;
            din[k] = 8'h00;
        end
        model_reset();
        test_reset();
        test_single_frame();
        test_parity();
        test_data7();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
